// File: rtl/cv32e40x_rf_wr_arbiter_if.sv
// Coprocessor (XIF) result bus into the register-file write arbiter.
// A result transfers on a clock edge where valid && ready; the producer holds valid/we/rd/data stable until then.
interface cv32e40x_rf_wr_arbiter_if;
   logic        valid;
   logic        ready;
   logic [1:0]  we;
   logic [4:0]  rd;
   logic [63:0] data;

   modport master (output valid, we, rd, data, input ready);
   modport slave  (input valid, we, rd, data, output ready);
endinterface

// File: rtl/cv32e40x_rf_wr_arbiter.sv
// Dual register-file write port arbiter: in-order WB writeback always wins, displaced coprocessor
// results wait in a small FIFO that a starvation counter drains by stalling WB.
module cv32e40x_rf_wr_arbiter #(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             wb_we_i,
   input  logic [4:0]             wb_waddr_i,
   input  logic [63:0]            wb_wdata_i,
   cv32e40x_rf_wr_arbiter_if.slave xif,
   output logic [1:0]             rf_we_o,
   output logic [1:0][4:0]        rf_waddr_o,
   output logic [63:0]            rf_wdata_o,
   output logic                   wb_stall_o,
   output logic                   xif_pending_o,
   output logic [31:0]            xif_pending_mask_o,
   output logic [1:0]             state_dbg
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(MAX_WAIT) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FORCE = 2'd2
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   wait_q;

   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_nxt;
   logic [1:0]       we_q   [DEPTH];
   logic [4:0]       rd_q   [DEPTH];
   logic [63:0]      data_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    wr_ptr_q;

   logic wb_wr;
   logic full;
   logic empty;
   logic xif_wr;
   logic bypass;
   logic pop;
   logic push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      return p + 1'b1;
   endfunction

   // A buffered bit dies when the newer in-order WB write targets the same register.
   function automatic logic [1:0] waw_kill(input logic [4:0] rd, input logic [1:0] wb_we,
                                           input logic [4:0] wb_rd);
      logic [4:0] rd_hi;
      logic [4:0] wb_hi;
      rd_hi = rd ^ 5'd1;
      wb_hi = wb_rd ^ 5'd1;
      waw_kill[0] = (wb_we[0] && (rd == wb_rd))    || (wb_we[1] && (rd == wb_hi));
      waw_kill[1] = (wb_we[0] && (rd_hi == wb_rd)) || (wb_we[1] && (rd_hi == wb_hi));
   endfunction

   assign wb_wr   = |wb_we_i;
   assign full    = &vld_q;
   assign empty   = ~|vld_q;
   assign xif_wr  = xif.valid & (|xif.we);
   assign bypass  = ~wb_wr & empty & xif_wr;
   assign pop     = ~wb_wr & ~empty;
   assign push    = xif_wr & ~full & ~bypass;

   assign xif.ready     = ~full;
   assign xif_pending_o = ~empty;
   assign state_dbg     = state_q;

   always_comb begin
      rf_we_o    = '0;
      rf_waddr_o = '0;
      rf_wdata_o = '0;
      if (!rst_n) begin
         rf_we_o = '0;
      end else if (wb_wr) begin
         rf_we_o       = wb_we_i;
         rf_waddr_o[0] = wb_waddr_i;
         rf_waddr_o[1] = wb_waddr_i ^ 5'd1;
         rf_wdata_o    = wb_wdata_i;
      end else if (!empty) begin
         // A fully killed head still pops here, with rf_we_o = 0.
         rf_we_o       = we_q[rd_ptr_q];
         rf_waddr_o[0] = rd_q[rd_ptr_q];
         rf_waddr_o[1] = rd_q[rd_ptr_q] ^ 5'd1;
         rf_wdata_o    = data_q[rd_ptr_q];
      end else if (bypass) begin
         rf_we_o       = xif.we;
         rf_waddr_o[0] = xif.rd;
         rf_waddr_o[1] = xif.rd ^ 5'd1;
         rf_wdata_o    = xif.data;
      end
   end

   always_comb begin
      vld_nxt = vld_q;
      if (pop)  vld_nxt[rd_ptr_q] = 1'b0;
      if (push) vld_nxt[wr_ptr_q] = 1'b1;
   end

   always_comb begin
      xif_pending_mask_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && we_q[i][0]) xif_pending_mask_o[rd_q[i]] = 1'b1;
         if (vld_q[i] && we_q[i][1]) xif_pending_mask_o[rd_q[i] ^ 5'd1] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         vld_q <= vld_nxt;
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
   end

   // Payload needs no reset; vld_q gates every use of it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wb_wr && vld_q[i]) we_q[i] <= we_q[i] & ~waw_kill(rd_q[i], wb_we_i, wb_waddr_i);
      end
      if (push) begin
         we_q[wr_ptr_q]   <= xif.we;
         rd_q[wr_ptr_q]   <= xif.rd;
         data_q[wr_ptr_q] <= xif.data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wait_q     <= '0;
         wb_stall_o <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (push) begin
                  state_q <= HOLD;
                  wait_q  <= '0;
               end
            end
            HOLD: begin
               if (pop) begin
                  wait_q <= '0;
                  if (!(|vld_nxt)) state_q <= IDLE;
               end else if (wait_q == CW'(MAX_WAIT - 1)) begin
                  state_q    <= FORCE;
                  wb_stall_o <= 1'b1;
               end else if (wait_q != '1) begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            FORCE: begin
               // A WB write here still wins; we just stay until the head drains.
               if (pop) begin
                  wait_q     <= '0;
                  wb_stall_o <= 1'b0;
                  state_q    <= (|vld_nxt) ? HOLD : IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               wait_q     <= '0;
               wb_stall_o <= 1'b0;
            end
         endcase
      end
   end

   wb_idle_in_force: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == FORCE) |-> !wb_wr);

endmodule

// File: tb/tb_cv32e40x_rf_wr_arbiter.sv
// Directed bench for cv32e40x_rf_wr_arbiter: bypass, buffering, starvation drain, full, WAW kill, reset.
module tb_cv32e40x_rf_wr_arbiter;
   localparam int unsigned DEPTH    = 2;
   localparam int unsigned MAX_WAIT = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      wb_we;
   logic [4:0]      wb_waddr;
   logic [63:0]     wb_wdata;
   logic [1:0]      rf_we;
   logic [1:0][4:0] rf_waddr;
   logic [63:0]     rf_wdata;
   logic            wb_stall;
   logic            xif_pending;
   logic [31:0]     xif_pending_mask;
   logic [1:0]      state_dbg;

   int n_chk  = 0;
   int n_fail = 0;
   logic [70:0] exp_q[$];

   cv32e40x_rf_wr_arbiter_if xif_bus ();

   always #5 clk = ~clk;

   cv32e40x_rf_wr_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .wb_we_i            (wb_we),
      .wb_waddr_i         (wb_waddr),
      .wb_wdata_i         (wb_wdata),
      .xif                (xif_bus),
      .rf_we_o            (rf_we),
      .rf_waddr_o         (rf_waddr),
      .rf_wdata_o         (rf_wdata),
      .wb_stall_o         (wb_stall),
      .xif_pending_o      (xif_pending),
      .xif_pending_mask_o (xif_pending_mask),
      .state_dbg          (state_dbg)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wb(input logic [1:0] we, input logic [4:0] rd, input logic [63:0] d);
      wb_we    = we;
      wb_waddr = rd;
      wb_wdata = d;
   endtask

   task automatic drive_xif(input logic v, input logic [1:0] we, input logic [4:0] rd,
                            input logic [63:0] d);
      xif_bus.valid = v;
      xif_bus.we    = we;
      xif_bus.rd    = rd;
      xif_bus.data  = d;
   endtask

   task automatic idle();
      drive_wb(2'b00, 5'd0, 64'd0);
      drive_xif(1'b0, 2'b00, 5'd0, 64'd0);
   endtask

   task automatic check_sb(input string tag);
      logic [70:0] e;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: expected queue empty", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_we"},    {62'd0, rf_we},  {62'd0, e[70:69]});
         check({tag, "_addr"},  {59'd0, rf_waddr[0]}, {59'd0, e[68:64]});
         check({tag, "_data"},  rf_wdata, e[63:0]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: rf_we must stay low even with WB driving.
      rst_n = 1'b0;
      idle();
      drive_wb(2'b11, 5'd3, 64'h1);
      cyc();
      #2;
      check("rst_rf_we", {62'd0, rf_we}, 64'd0);
      idle();
      cyc();
      rst_n = 1'b1;
      #2;
      check("rst_ready",   {63'd0, xif_bus.ready}, 64'd1);
      check("rst_pending", {63'd0, xif_pending}, 64'd0);
      check("rst_mask",    {32'd0, xif_pending_mask}, 64'd0);
      check("rst_stall",   {63'd0, wb_stall}, 64'd0);
      check("rst_state",   {62'd0, state_dbg}, 64'd0);

      // 1: bypass into an empty FIFO
      drive_xif(1'b1, 2'b11, 5'd5, 64'hAAAA_BBBB_CCCC_DDDD);
      #2;
      check("t1_we",    {62'd0, rf_we}, 64'd3);
      check("t1_addr0", {59'd0, rf_waddr[0]}, 64'd5);
      check("t1_addr1", {59'd0, rf_waddr[1]}, 64'd4);
      check("t1_data",  rf_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
      cyc();
      idle();
      #2;
      check("t1_pending", {63'd0, xif_pending}, 64'd0);
      check("t1_mask",    {32'd0, xif_pending_mask}, 64'd0);
      cyc();

      // 2: WB wins, XIF buffered one cycle
      drive_wb(2'b01, 5'd8, 64'h0000_0000_1111_2222);
      drive_xif(1'b1, 2'b11, 5'd10, 64'h2020_2020_1010_1010);
      #2;
      check("t2_wb_we",   {62'd0, rf_we}, 64'd1);
      check("t2_wb_addr", {59'd0, rf_waddr[0]}, 64'd8);
      check("t2_wb_data", rf_wdata, 64'h0000_0000_1111_2222);
      cyc();
      idle();
      #2;
      check("t2_pending", {63'd0, xif_pending}, 64'd1);
      check("t2_mask",    {32'd0, xif_pending_mask}, 64'h0C00);
      check("t2_we",      {62'd0, rf_we}, 64'd3);
      check("t2_addr0",   {59'd0, rf_waddr[0]}, 64'd10);
      check("t2_addr1",   {59'd0, rf_waddr[1]}, 64'd11);
      check("t2_data",    rf_wdata, 64'h2020_2020_1010_1010);
      cyc();
      #2;
      check("t2_mask_clr", {32'd0, xif_pending_mask}, 64'd0);
      check("t2_pend_clr", {63'd0, xif_pending}, 64'd0);
      cyc();

      // 3: starvation drain after MAX_WAIT cycles of WB writes
      drive_wb(2'b01, 5'd1, 64'h33);
      drive_xif(1'b1, 2'b01, 5'd6, 64'h0000_0006_0000_0666);
      cyc();
      drive_xif(1'b0, 2'b00, 5'd0, 64'd0);
      for (int k = 1; k <= 4; k++) begin
         #2;
         check($sformatf("t3_stall_c%0d", k), {63'd0, wb_stall}, 64'd0);
         check($sformatf("t3_state_c%0d", k), {62'd0, state_dbg}, 64'd1);
         cyc();
      end
      idle();
      #2;
      check("t3_stall_on", {63'd0, wb_stall}, 64'd1);
      check("t3_state_force", {62'd0, state_dbg}, 64'd2);
      check("t3_we",    {62'd0, rf_we}, 64'd1);
      check("t3_addr0", {59'd0, rf_waddr[0]}, 64'd6);
      check("t3_data",  rf_wdata, 64'h0000_0006_0000_0666);
      cyc();
      #2;
      check("t3_stall_off", {63'd0, wb_stall}, 64'd0);
      check("t3_state_idle", {62'd0, state_dbg}, 64'd0);
      check("t3_pending", {63'd0, xif_pending}, 64'd0);
      cyc();

      // 4: fill to full, backpressure, FIFO order
      drive_wb(2'b01, 5'd1, 64'h44);
      drive_xif(1'b1, 2'b01, 5'd14, 64'hA);
      exp_q.push_back({2'b01, 5'd14, 64'hA});
      #2;
      check("t4_ready_a", {63'd0, xif_bus.ready}, 64'd1);
      cyc();
      drive_xif(1'b1, 2'b10, 5'd16, 64'hB);
      exp_q.push_back({2'b10, 5'd16, 64'hB});
      #2;
      check("t4_ready_b", {63'd0, xif_bus.ready}, 64'd1);
      cyc();
      drive_xif(1'b1, 2'b11, 5'd18, 64'hC);
      exp_q.push_back({2'b11, 5'd18, 64'hC});
      #2;
      check("t4_ready_full", {63'd0, xif_bus.ready}, 64'd0);
      check("t4_mask_full",  {32'd0, xif_pending_mask}, 64'h24000);
      cyc();
      drive_wb(2'b00, 5'd0, 64'd0);
      #2;
      check("t4_ready_pop", {63'd0, xif_bus.ready}, 64'd0);
      check_sb("t4_a");
      cyc();
      #2;
      check("t4_ready_rel", {63'd0, xif_bus.ready}, 64'd1);
      check_sb("t4_b");
      check("t4_b_addr1", {59'd0, rf_waddr[1]}, 64'd17);
      cyc();
      drive_xif(1'b0, 2'b00, 5'd0, 64'd0);
      #2;
      check_sb("t4_c");
      cyc();
      #2;
      check("t4_pending", {63'd0, xif_pending}, 64'd0);
      cyc();

      // 5: WAW kill of one half of a buffered pair
      drive_wb(2'b01, 5'd20, 64'h55);
      drive_xif(1'b1, 2'b11, 5'd12, 64'hEEEE_0000_EEEE_1111);
      cyc();
      drive_xif(1'b0, 2'b00, 5'd0, 64'd0);
      drive_wb(2'b01, 5'd13, 64'h56);
      #2;
      check("t5_mask_before", {32'd0, xif_pending_mask}, 64'h3000);
      cyc();
      idle();
      #2;
      check("t5_mask_after", {32'd0, xif_pending_mask}, 64'h1000);
      check("t5_pending",    {63'd0, xif_pending}, 64'd1);
      check("t5_we",         {62'd0, rf_we}, 64'd1);
      check("t5_addr0",      {59'd0, rf_waddr[0]}, 64'd12);
      check("t5_data",       rf_wdata, 64'hEEEE_0000_EEEE_1111);
      cyc();

      // 5b: fully killed entry drains without a write
      drive_wb(2'b01, 5'd2, 64'h57);
      drive_xif(1'b1, 2'b01, 5'd22, 64'hF);
      cyc();
      drive_xif(1'b0, 2'b00, 5'd0, 64'd0);
      drive_wb(2'b01, 5'd22, 64'h58);
      #2;
      check("t5b_mask_before", {32'd0, xif_pending_mask}, 64'h40_0000);
      cyc();
      idle();
      #2;
      check("t5b_mask_after", {32'd0, xif_pending_mask}, 64'd0);
      check("t5b_pending",    {63'd0, xif_pending}, 64'd1);
      check("t5b_no_write",   {62'd0, rf_we}, 64'd0);
      cyc();
      #2;
      check("t5b_drained", {63'd0, xif_pending}, 64'd0);
      cyc();

      // 6: mid-operation reset drops buffered results
      drive_wb(2'b01, 5'd1, 64'h66);
      drive_xif(1'b1, 2'b01, 5'd3, 64'h3);
      cyc();
      drive_xif(1'b1, 2'b01, 5'd7, 64'h7);
      cyc();
      idle();
      #2;
      check("t6_full", {63'd0, xif_bus.ready}, 64'd0);
      rst_n = 1'b0;
      #1;
      check("t6_rf_in_rst", {62'd0, rf_we}, 64'd0);
      cyc();
      rst_n = 1'b1;
      #2;
      check("t6_pending", {63'd0, xif_pending}, 64'd0);
      check("t6_mask",    {32'd0, xif_pending_mask}, 64'd0);
      check("t6_ready",   {63'd0, xif_bus.ready}, 64'd1);
      check("t6_no_write", {62'd0, rf_we}, 64'd0);
      cyc();
      #2;
      check("t6_no_write2", {62'd0, rf_we}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
